// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter: FU indices, tag widths,
// the broadcast record layout and the ROB age comparison used by the flush logic.
package cdb_arbiter_pkg;

  localparam int NUM_FU    = 3;
  localparam int QDEPTH    = 2;
  localparam int ROB_TAG_W = 5;
  localparam int PREG_W    = 7;
  localparam int DATA_W    = 32;

  localparam int FU_ALU = 0;
  localparam int FU_MEM = 1;
  localparam int FU_BR  = 2;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [1:0]           fu_idx_t;

  typedef struct packed {
    logic              we;
    preg_t             pd;
    rob_tag_t          rob_tag;
    logic [DATA_W-1:0] data;
  } cdb_data_t;

  // Ages are distances from the ROB head; the tag-width subtraction provides the modulo.
  function automatic logic is_younger(rob_tag_t tag, rob_tag_t br_tag, rob_tag_t head);
    rob_tag_t age_tag;
    rob_tag_t age_br;
    age_tag = tag - head;
    age_br  = br_tag - head;
    return age_tag > age_br;
  endfunction

  function automatic fu_idx_t wrap_idx(int v);
    return fu_idx_t'(v % NUM_FU);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result handshakes, ROB age/flush inputs and the CDB broadcast outputs.
// slave = the arbiter; master = the execution core surrounding it.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]                fu_valid;
  logic [NUM_FU-1:0]                fu_ready;
  logic [NUM_FU-1:0]                fu_we;
  logic [NUM_FU-1:0][PREG_W-1:0]    fu_pd;
  logic [NUM_FU-1:0][ROB_TAG_W-1:0] fu_rob_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]    fu_data;

  logic [ROB_TAG_W-1:0] rob_head;
  logic                 mispredict;
  logic [ROB_TAG_W-1:0] mispredict_tag;

  logic                 cdb_valid;
  logic                 cdb_we;
  logic [PREG_W-1:0]    cdb_pd;
  logic [ROB_TAG_W-1:0] cdb_rob_tag;
  logic [DATA_W-1:0]    cdb_data;

  modport slave (
    input  fu_valid, fu_we, fu_pd, fu_rob_tag, fu_data,
    input  rob_head, mispredict, mispredict_tag,
    output fu_ready,
    output cdb_valid, cdb_we, cdb_pd, cdb_rob_tag, cdb_data
  );

  modport master (
    output fu_valid, fu_we, fu_pd, fu_rob_tag, fu_data,
    output rob_head, mispredict, mispredict_tag,
    input  fu_ready,
    input  cdb_valid, cdb_we, cdb_pd, cdb_rob_tag, cdb_data
  );

endinterface

// File: rtl/cdb_fu_queue.sv
// Two-entry per-FU result FIFO. Entries younger than a mispredicted branch are dropped
// at the flush edge and the survivors compact toward slot 0, so slot 0 is always oldest.
module cdb_fu_queue
  import cdb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      enq_valid,
  input  cdb_data_t enq_data,
  output logic      enq_ready,
  input  logic      deq,
  output logic      head_valid,
  output cdb_data_t head_data,
  input  logic      flush,
  input  rob_tag_t  flush_tag,
  input  rob_tag_t  rob_head
);

  logic [QDEPTH-1:0]      valid_q, valid_d;
  cdb_data_t [QDEPTH-1:0] entry_q, entry_d;
  logic [QDEPTH-1:0]      keep;
  logic [QDEPTH-1:0]      remain;
  logic                   enq_fire;

  // Ready looks only at stored occupancy, never at this cycle's dequeue.
  assign enq_ready = ~&valid_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    keep     = '0;
    remain   = '0;
    valid_d  = '0;
    entry_d  = entry_q;
    enq_fire = 1'b0;

    for (int j = 0; j < QDEPTH; j++) begin
      keep[j] = valid_q[j] && !(flush && is_younger(entry_q[j].rob_tag, flush_tag, rob_head));
    end

    head_valid = |keep;
    head_data  = keep[0] ? entry_q[0] : entry_q[1];

    remain = keep;
    if (deq) begin
      if (keep[0]) remain[0] = 1'b0;
      else         remain[1] = 1'b0;
    end

    if (remain[0]) begin
      valid_d[0] = 1'b1;
      valid_d[1] = remain[1];
    end else if (remain[1]) begin
      entry_d[0] = entry_q[1];
      valid_d[0] = 1'b1;
    end

    enq_fire = enq_valid && enq_ready &&
               !(flush && is_younger(enq_data.rob_tag, flush_tag, rob_head));
    if (enq_fire) begin
      if (valid_d[0]) begin
        entry_d[1] = enq_data;
        valid_d[1] = 1'b1;
      end else begin
        entry_d[0] = enq_data;
        valid_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: payload storage is not reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result per cycle from the FU queue heads, round-robin,
// into a registered broadcast toward the PRF, reservation stations and ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clk,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  cdb_data_t         fu_in     [NUM_FU];
  cdb_data_t         head_data [NUM_FU];
  logic [NUM_FU-1:0] head_valid;
  logic [NUM_FU-1:0] fu_ready;
  logic [NUM_FU-1:0] grant;

  fu_idx_t   rr_ptr_q, rr_ptr_d;
  fu_idx_t   cand, gsel;
  logic      found;
  logic      cdb_valid_q, cdb_valid_d;
  cdb_data_t cdb_q, cdb_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_in[i] = '{we:      bus.fu_we[i],
                        pd:      bus.fu_pd[i],
                        rob_tag: bus.fu_rob_tag[i],
                        data:    bus.fu_data[i]};

    cdb_fu_queue u_queue (
      .clk        (clk),
      .reset      (reset),
      .enq_valid  (bus.fu_valid[i]),
      .enq_data   (fu_in[i]),
      .enq_ready  (fu_ready[i]),
      .deq        (grant[i]),
      .head_valid (head_valid[i]),
      .head_data  (head_data[i]),
      .flush      (bus.mispredict),
      .flush_tag  (bus.mispredict_tag),
      .rob_head   (bus.rob_head)
    );
  end

  // Search starts at rr_ptr; the winner's successor becomes the new highest priority.
  always_comb begin
    grant       = '0;
    cand        = '0;
    gsel        = '0;
    found       = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_d       = cdb_q;

    for (int k = 0; k < NUM_FU; k++) begin
      cand = wrap_idx(int'(rr_ptr_q) + k);
      if (!found && head_valid[cand]) begin
        found = 1'b1;
        gsel  = cand;
      end
    end

    if (found) begin
      grant[gsel] = 1'b1;
      rr_ptr_d    = wrap_idx(int'(gsel) + 1);
      cdb_valid_d = 1'b1;
      cdb_d       = head_data[gsel];
    end
  end

  // The broadcast register reloads or drops valid every edge, so a younger entry
  // sitting in it at a flush edge is never held over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  assign bus.fu_ready    = fu_ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_we      = cdb_q.we;
  assign bus.cdb_pd      = cdb_q.pd;
  assign bus.cdb_rob_tag = cdb_q.rob_tag;
  assign bus.cdb_data    = cdb_q.data;

endmodule
